// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Write-side companion of the register file. Queues ALU and
//               memory-load results in an in-order FIFO. Drains one entry per
//               cycle onto the register file write port while decode is not
//               holding the read port. Publishes a per-register pending
//               scoreboard so decode can stall on read-after-write hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int DEPTH = 4,   // FIFO entries, power of two, >= 2
  parameter int WIDTH = 16,  // data width
  parameter int NREGS = 16   // register count
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [$clog2(NREGS)-1:0]   mem_num,
  input  logic [WIDTH-1:0]           mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [$clog2(NREGS)-1:0]   alu_num,
  input  logic [WIDTH-1:0]           alu_data,
  input  logic                       rd_hold,
  output logic [1:0]                 rf_write,
  output logic [$clog2(NREGS)-1:0]   rf_num1,
  output logic [WIDTH-1:0]           rf_data,
  output logic [NREGS-1:0]           pending,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(NREGS);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]    C_DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0]    C_DEPTH_M2 = CW'(DEPTH - 2);
  localparam logic [NREGS-1:0] C_ONE_HOT  = {{(NREGS-1){1'b0}}, 1'b1};

  // FIFO storage and control
  logic [NW-1:0]    num_q  [DEPTH];
  logic [NW-1:0]    num_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Register file write port registers
  logic [1:0]       rf_write_q, rf_write_d;
  logic [NW-1:0]    rf_num1_q, rf_num1_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;

  logic             mem_acc;
  logic             alu_acc;
  logic             pop;
  logic [AW-1:0]    alu_slot;
  logic [NREGS-1:0] pending_w;

  // Conservative acceptance: space is judged on current occupancy only, and
  // the ALU yields a slot to a simultaneously valid memory result.
  assign mem_ready = !rst && (count_q <= C_DEPTH_M1);
  assign alu_ready = !rst && (mem_valid ? (count_q <= C_DEPTH_M2)
                                        : (count_q <= C_DEPTH_M1));
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign pop       = (count_q != '0) && !rd_hold;
  // Memory result takes the first free slot, so same-register ALU data lands last
  assign alu_slot  = wr_ptr_q + AW'(mem_acc);

  // Next-state for FIFO pointers, contents and the write-port registers
  always_comb begin
    num_d      = num_q;
    data_d     = data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + AW'(mem_acc) + AW'(alu_acc);
    count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    rf_write_d = 2'b00;
    rf_num1_d  = rf_num1_q;
    rf_data_d  = rf_data_q;

    if (pop) begin
      rf_write_d = 2'b01;
      rf_num1_d  = num_q[rd_ptr_q];
      rf_data_d  = data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end

    if (mem_acc) begin
      num_d[wr_ptr_q]  = mem_num;
      data_d[wr_ptr_q] = mem_data;
    end

    if (alu_acc) begin
      num_d[alu_slot]  = alu_num;
      data_d[alu_slot] = alu_data;
    end
  end

  // State registers with synchronous reset; reset drops queued and in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        num_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rf_write_q <= 2'b00;
      rf_num1_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      num_q      <= num_d;
      data_q     <= data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rf_write_q <= rf_write_d;
      rf_num1_q  <= rf_num1_d;
      rf_data_q  <= rf_data_d;
    end
  end

  // Scoreboard: every occupied FIFO slot plus the write currently on the port
  always_comb begin
    pending_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pending_w = pending_w | (C_ONE_HOT << num_q[rd_ptr_q + AW'(k)]);
      end
    end
    if (rf_write_q[0]) begin
      pending_w = pending_w | (C_ONE_HOT << rf_num1_q);
    end
  end

  assign rf_write = rf_write_q;
  assign rf_num1  = rf_num1_q;
  assign rf_data  = rf_data_q;
  assign pending  = pending_w;
  assign count    = count_q;
  assign busy     = (count_q != '0) || (rf_write_q != 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Self-checking bench for reg_writeback. A queue-based model
//               tracks expected outputs every cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_num = '0;
  logic [15:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [3:0]  alu_num = '0;
  logic [15:0] alu_data = '0;
  logic        rd_hold = 1'b0;
  logic [1:0]  rf_write;
  logic [3:0]  rf_num1;
  logic [15:0] rf_data;
  logic [15:0] pending;
  logic [2:0]  count;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  reg_writeback #(.DEPTH(DEPTH), .WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_num(mem_num), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_num(alu_num), .alu_data(alu_data),
    .rd_hold(rd_hold),
    .rf_write(rf_write), .rf_num1(rf_num1), .rf_data(rf_data),
    .pending(pending), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  num;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_rfw  = 1'b0;
  logic [3:0]  m_num  = '0;
  logic [15:0] m_data = '0;

  always @(posedge clk) begin : model
    int  sz;
    bit  macc, aacc;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_rfw  = 1'b0;
      m_num  = '0;
      m_data = '0;
    end else begin
      macc = mem_valid && (sz <= DEPTH - 1);
      aacc = alu_valid && (mem_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1));
      if (sz != 0 && !rd_hold) begin
        m_rfw  = 1'b1;
        m_num  = mq[0].num;
        m_data = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_rfw = 1'b0;
      end
      if (macc) mq.push_back('{mem_num, mem_data});
      if (aacc) mq.push_back('{alu_num, alu_data});
    end
  end

  // Compare DUT against the model on every falling edge once out of reset
  always @(negedge clk) begin : compare
    int         sz;
    logic [15:0] epend;
    bit         emr, ear;
    if (chk_en) begin
      sz    = mq.size();
      epend = '0;
      foreach (mq[i]) epend[mq[i].num] = 1'b1;
      if (m_rfw) epend[m_num] = 1'b1;
      emr = !rst && (sz <= DEPTH - 1);
      ear = !rst && (mem_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1));
      chk("mdl_mem_ready", mem_ready, emr);
      chk("mdl_alu_ready", alu_ready, ear);
      chk("mdl_rf_write", rf_write, {1'b0, m_rfw});
      chk("mdl_rf_num1", rf_num1, m_num);
      chk("mdl_rf_data", rf_data, m_data);
      chk("mdl_pending", pending, epend);
      chk("mdl_count", count, sz);
      chk("mdl_busy", busy, (sz != 0) || m_rfw);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset
    step();
    step();
    chk_en = 1'b1;
    chk("rst_rf_write", rf_write, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    rst = 1'b0;

    // Single ALU write to r3
    alu_valid = 1'b1; alu_num = 4'd3; alu_data = 16'hBEEF;
    #1 chk("t1_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("t1_pend_acc", pending, 16'h0008);
    chk("t1_wr_idle", rf_write, 2'b00);
    step();
    chk("t1_rf_write", rf_write, 2'b01);
    chk("t1_rf_num1", rf_num1, 3);
    chk("t1_rf_data", rf_data, 16'hBEEF);
    chk("t1_pend_wr", pending, 16'h0008);
    step();
    chk("t1_pend_clr", pending, 16'h0000);
    chk("t1_busy_clr", busy, 0);

    // Same-cycle mem and ALU to r5: mem first
    mem_valid = 1'b1; mem_num = 4'd5; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_num = 4'd5; alu_data = 16'h2222;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("t2_count", count, 2);
    chk("t2_pend0", pending, 16'h0020);
    step();
    chk("t2_data0", rf_data, 16'h1111);
    chk("t2_pend1", pending, 16'h0020);
    step();
    chk("t2_data1", rf_data, 16'h2222);
    chk("t2_pend2", pending, 16'h0020);
    step();
    chk("t2_pend3", pending, 16'h0000);

    // Fill under rd_hold, then drain in order
    rd_hold = 1'b1;
    alu_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_num = 4'(i); alu_data = 16'hA000 + 16'(i);
      step();
    end
    alu_valid = 1'b0;
    #1;
    chk("t3_count_full", count, 4);
    chk("t3_mem_ready", mem_ready, 0);
    chk("t3_alu_ready", alu_ready, 0);
    chk("t3_no_write", rf_write, 2'b00);
    rd_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3_drain_wr", rf_write, 2'b01);
      chk("t3_drain_num", rf_num1, i);
      chk("t3_drain_data", rf_data, 16'hA000 + 16'(i));
      chk("t3_drain_cnt", count, 4 - i);
    end
    chk("t3_busy_last", busy, 1);
    step();
    chk("t3_busy_done", busy, 0);

    // count=3 with both valid: only mem accepted
    rd_hold = 1'b1;
    alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_num = 4'(i + 12); alu_data = 16'hC000 + 16'(i);
      step();
    end
    mem_valid = 1'b1; mem_num = 4'd9; mem_data = 16'h9999;
    alu_num = 4'd8; alu_data = 16'h8888;
    #1;
    chk("t4_mem_ready", mem_ready, 1);
    chk("t4_alu_ready", alu_ready, 0);
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("t4_count", count, 4);
    rd_hold = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_last_num", rf_num1, 9);
    chk("t4_last_data", rf_data, 16'h9999);
    step();
    chk("t4_empty", count, 0);

    // rd_hold toggling with two queued entries
    rd_hold = 1'b1;
    alu_valid = 1'b1;
    alu_num = 4'd6; alu_data = 16'h0606; step();
    alu_num = 4'd7; alu_data = 16'h0707; step();
    alu_valid = 1'b0;
    rd_hold = 1'b1; step(); chk("t5_h1", rf_write, 2'b00);
    rd_hold = 1'b0; step(); chk("t5_r1", rf_write, 2'b01); chk("t5_r1_num", rf_num1, 6);
    rd_hold = 1'b1; step(); chk("t5_h2", rf_write, 2'b00);
    rd_hold = 1'b0; step(); chk("t5_r2", rf_write, 2'b01); chk("t5_r2_num", rf_num1, 7);
    step(); chk("t5_idle", rf_write, 2'b00);

    // Reset mid-drain
    rd_hold = 1'b1;
    alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_num = 4'(i + 10); alu_data = 16'hD000 + 16'(i);
      step();
    end
    alu_valid = 1'b0;
    rd_hold = 1'b0;
    step();
    chk("t6_drain", rf_write, 2'b01);
    chk("t6_cnt", count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_wr", rf_write, 2'b00);
    chk("t6_rst_cnt", count, 0);
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_write", rf_write, 2'b00);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
